display_scan_decoder: RTL and testbench

- Reads the multiplexed display bus that the alarm-clock datapath drives: `display_out`, `segment_digit`, `am`, `pm`, `days`.
- Reconstructs the four displayed digits as BCD and publishes a coherent frame once per complete scan.
- Flags illegal segment patterns, scan-order faults and a stalled scan.
- Sits beside the datapath as its receiver; it feeds status registers and the system-level bench monitor.

---
 rtl/display_scan_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_display_scan_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_decoder.sv
// display_scan_decoder
//   Receiver for the multiplexed alarm-clock display bus. It samples each digit
//   once it has been selected for SETTLE cycles and decodes the 7-segment code
//   into BCD. After a complete 0..3 scan it publishes a coherent frame. It also
//   flags illegal segment codes, scan-order faults and a stalled scan.
//
//   Optional feature macro: CAPTURE_DAYS_EN
//     defined   : days is captured with digit 3, and a non-one-hot nonzero days
//                 value is treated as a segment error.
//     undefined : days is ignored and days_q stays 0.
//
// Ports
//   Clk, Reset     clock, asynchronous active-low reset
//   display_out    segment bus, gfedcba, active-high
//   segment_digit  one-hot digit select (bit 0 = minutes ones)
//   am, pm, days   indicators sampled with digit 3
//   time_bcd       committed digits, [3:0] = digit 0
//   blank_mask     per-digit blank flags of the last frame
//   am_q, pm_q     committed meridian flags
//   days_q         committed days (0 when CAPTURE_DAYS_EN is undefined)
//   frame_valid    one-cycle pulse when a new frame takes effect
//   order_err      one-cycle pulse on a frame aborted by order/select fault
//   seg_err        sticky illegal-pattern flag
//   stale          set on scan timeout, cleared by the next frame
module display_scan_decoder #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [6:0]  display_out,
  input  logic [3:0]  segment_digit,
  input  logic        am,
  input  logic        pm,
  input  logic [6:0]  days,
  output logic [15:0] time_bcd,
  output logic [3:0]  blank_mask,
  output logic        am_q,
  output logic        pm_q,
  output logic [6:0]  days_q,
  output logic        frame_valid,
  output logic        order_err,
  output logic        seg_err,
  output logic        stale
);

  localparam int SW = (SETTLE  < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, SCAN, COMMIT} state_t;

  state_t        state;
  logic [1:0]    expected;
  logic [3:0]    sel_q;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [TW-1:0] idle_cnt, idle_nxt;
  logic          sample, t_hit;
  logic          one_hot;
  logic [1:0]    idx;
  logic [3:0]    dec_val;
  logic          dec_ok, dec_blank;
  logic          days_bad, bad_seg, store;
  logic [15:0]   shd_bcd;
  logic [3:0]    shd_blank;
  logic          shd_am, shd_pm;
  logic [6:0]    shd_days;

  // Settle counter: a hold yields exactly one sample, on the cycle the count
  // first reaches SETTLE; afterwards it saturates until the select changes.
  always_comb begin
    if (segment_digit == 4'b0000)
      settle_nxt = '0;
    else if (segment_digit != sel_q)
      settle_nxt = SW'(1);
    else if (settle_cnt == SW'(SETTLE))
      settle_nxt = settle_cnt;
    else
      settle_nxt = settle_cnt + 1'b1;
  end

  assign sample = (settle_nxt == SW'(SETTLE)) &&
                  !((segment_digit == sel_q) && (settle_cnt == SW'(SETTLE)));

  always_comb begin
    if (sample)
      idle_nxt = '0;
    else if (idle_cnt == TW'(TIMEOUT))
      idle_nxt = idle_cnt;
    else
      idle_nxt = idle_cnt + 1'b1;
  end

  assign t_hit = (idle_nxt == TW'(TIMEOUT)) && (idle_cnt != TW'(TIMEOUT));

  assign one_hot = $onehot(segment_digit);

  always_comb begin
    case (segment_digit)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'd0;
    case (display_out)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end

`ifdef CAPTURE_DAYS_EN
  assign days_bad = !$onehot0(days);
`else
  logic days_unused;
  assign days_unused = ^days;
  assign days_bad    = 1'b0;
  assign shd_days    = '0;
`endif

  // Samples arriving during the single COMMIT cycle are not interpreted.
  assign bad_seg = sample && one_hot && (state != COMMIT) &&
                   (!dec_ok || ((idx == 2'd3) && days_bad));

  // A digit-0 sample restarts the frame even when it arrives out of order.
  assign store = sample && one_hot && !bad_seg &&
                 (((state == HUNT) && (idx == 2'd0)) ||
                  ((state == SCAN) && ((idx == expected) || (idx == 2'd0))));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shd_bcd   <= '0;
      shd_blank <= '0;
      shd_am    <= 1'b0;
      shd_pm    <= 1'b0;
`ifdef CAPTURE_DAYS_EN
      shd_days  <= '0;
`endif
    end else if (store) begin
      // A blank digit keeps its previous value and only raises its blank bit.
      if (!dec_blank)
        shd_bcd[{idx, 2'b00} +: 4] <= dec_val;
      shd_blank[idx] <= dec_blank;
      if (idx == 2'd3) begin
        shd_am   <= am;
        shd_pm   <= pm;
`ifdef CAPTURE_DAYS_EN
        shd_days <= days;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= HUNT;
      expected    <= 2'd0;
      sel_q       <= '0;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      time_bcd    <= '0;
      blank_mask  <= '0;
      am_q        <= 1'b0;
      pm_q        <= 1'b0;
      days_q      <= '0;
      frame_valid <= 1'b0;
      order_err   <= 1'b0;
      seg_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      sel_q       <= segment_digit;
      settle_cnt  <= settle_nxt;
      idle_cnt    <= idle_nxt;
      frame_valid <= 1'b0;
      order_err   <= 1'b0;
      if (bad_seg)
        seg_err <= 1'b1;
      case (state)
        HUNT: begin
          if (store) begin
            state    <= SCAN;
            expected <= 2'd1;
          end
        end
        SCAN: begin
          if (bad_seg) begin
            state <= HUNT;
          end else if (sample && !one_hot) begin
            order_err <= 1'b1;
            state     <= HUNT;
          end else if (sample && (idx != expected)) begin
            order_err <= 1'b1;
            if (idx == 2'd0)
              expected <= 2'd1;
            else
              state <= HUNT;
          end else if (sample) begin
            if (idx == 2'd3)
              state <= COMMIT;
            else
              expected <= expected + 2'd1;
          end
        end
        COMMIT: begin
          time_bcd    <= shd_bcd;
          blank_mask  <= shd_blank;
          am_q        <= shd_am;
          pm_q        <= shd_pm;
          days_q      <= shd_days;
          frame_valid <= 1'b1;
          stale       <= 1'b0;
          state       <= HUNT;
        end
        default: state <= HUNT;
      endcase
      if (t_hit) begin
        stale <= 1'b1;
        state <= HUNT;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_decoder.sv
module tb_display_scan_decoder;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [6:0]  display_out = '0;
  logic [3:0]  segment_digit = '0;
  logic        am = 1'b0, pm = 1'b0;
  logic [6:0]  days = '0;
  logic [15:0] time_bcd;
  logic [3:0]  blank_mask;
  logic        am_q, pm_q, frame_valid, order_err, seg_err, stale;
  logic [6:0]  days_q;

  display_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .display_out(display_out),
    .segment_digit(segment_digit), .am(am), .pm(pm), .days(days),
    .time_bcd(time_bcd), .blank_mask(blank_mask), .am_q(am_q), .pm_q(pm_q),
    .days_q(days_q), .frame_valid(frame_valid), .order_err(order_err),
    .seg_err(seg_err), .stale(stale)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int oe_cnt = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference model: scan position, shadow frame and expected outputs
  int         run, idle, mode, nexp;   // mode: 0 hunting, 1 scanning, 2 commit due
  logic [3:0] prev_sel;
  logic [3:0] sh [4];
  logic       shb [4];
  logic       sh_am, sh_pm;
  logic [6:0] sh_days;
  logic [3:0] o_d [4];
  logic       o_b [4];
  logic       o_am, o_pm, o_fv, o_oe, o_seg, o_stale;
  logic [6:0] o_days;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run = 0; idle = 0; mode = 0; nexp = 0; prev_sel = '0;
    for (int i = 0; i < 4; i++) begin
      sh[i] = '0; shb[i] = 1'b0; o_d[i] = '0; o_b[i] = 1'b0;
    end
    sh_am = 0; sh_pm = 0; sh_days = '0;
    o_am = 0; o_pm = 0; o_fv = 0; o_oe = 0; o_seg = 0; o_stale = 0; o_days = '0;
  endtask

  task automatic model_store(input int d, input logic [3:0] v, input logic blank);
    if (!blank) sh[d] = v;
    shb[d] = blank;
    if (d == 3) begin
      sh_am = am; sh_pm = pm;
`ifdef CAPTURE_DAYS_EN
      sh_days = days;
`endif
    end
  endtask

  task automatic model_step();
    logic acc, hit, oh, legal, blank;
    logic [3:0] v;
    int d, old_idle;
    o_fv = 0; o_oe = 0;
    if (segment_digit == 0) run = 0;
    else if (segment_digit != prev_sel) run = 1;
    else run++;
    prev_sel = segment_digit;
    acc = (run == SETTLE);
    old_idle = idle;
    if (acc) idle = 0;
    else if (idle < TIMEOUT) idle++;
    hit = !acc && (idle == TIMEOUT) && (old_idle != TIMEOUT);
    oh = ($countones(segment_digit) == 1);
    d = 0;
    for (int k = 0; k < 4; k++) if (segment_digit[k]) d = k;
    blank = (display_out == 0);
    legal = blank;
    v = 0;
    for (int k = 0; k < 10; k++)
      if (display_out == seg_tab[k]) begin legal = 1; v = 4'(k); end
`ifdef CAPTURE_DAYS_EN
    if (d == 3 && days != 0 && $countones(days) != 1) legal = 0;
`endif
    if (mode == 2) begin
      for (int i = 0; i < 4; i++) begin o_d[i] = sh[i]; o_b[i] = shb[i]; end
      o_am = sh_am; o_pm = sh_pm; o_days = sh_days;
      o_fv = 1; o_stale = 0; mode = 0;
    end else if (acc && oh && !legal) begin
      o_seg = 1; mode = 0;
    end else if (acc && !oh) begin
      if (mode == 1) begin o_oe = 1; mode = 0; end
    end else if (acc) begin
      if (mode == 0) begin
        if (d == 0) begin model_store(d, v, blank); mode = 1; nexp = 1; end
      end else if (d == nexp) begin
        model_store(d, v, blank);
        if (d == 3) mode = 2; else nexp++;
      end else begin
        o_oe = 1;
        if (d == 0) begin model_store(d, v, blank); nexp = 1; end
        else mode = 0;
      end
    end
    if (hit) begin o_stale = 1; mode = 0; end
  endtask

  task automatic check_all();
    check_val("time_bcd", time_bcd, {o_d[3], o_d[2], o_d[1], o_d[0]});
    check_val("blank_mask", blank_mask, {o_b[3], o_b[2], o_b[1], o_b[0]});
    check_val("am_q", am_q, o_am);
    check_val("pm_q", pm_q, o_pm);
    check_val("days_q", days_q, o_days);
    check_val("frame_valid", frame_valid, o_fv);
    check_val("order_err", order_err, o_oe);
    check_val("seg_err", seg_err, o_seg);
    check_val("stale", stale, o_stale);
  endtask

  task automatic cyc(input logic [3:0] s, input logic [6:0] p);
    segment_digit = s;
    display_out   = p;
    @(posedge Clk);
    model_step();
    #1;
    check_all();
    if (frame_valid) fv_cnt++;
    if (order_err) oe_cnt++;
  endtask

  task automatic hold(input logic [3:0] s, input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) cyc(s, p);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    hold(4'b0001, p0, 3);
    hold(4'b0010, p1, 3);
    hold(4'b0100, p2, 3);
    hold(4'b1000, p3, 3);
  endtask

  int fv0, oe0, r;
  logic [3:0] sel;
  logic [6:0] pat;

  initial begin
    model_reset();
    #1 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    check_val("rst_time_bcd", time_bcd, 16'h0000);
    #3 Reset = 1'b1;

    // clean scan
    pm = 1; am = 0; days = 7'b0000100;
    fv0 = fv_cnt;
    scan(7'h6D, 7'h4F, 7'h06, 7'h5B);
    check_val("clean_fv", fv_cnt - fv0, 1);
    check_val("clean_bcd", time_bcd, 16'h2135);
    check_val("clean_pm", pm_q, 1);
    check_val("clean_blank", blank_mask, 4'b0000);
`ifdef CAPTURE_DAYS_EN
    check_val("clean_days", days_q, 7'b0000100);
`else
    check_val("clean_days", days_q, 7'b0000000);
`endif

    // blink
    scan(7'h6D, 7'h00, 7'h06, 7'h5B);
    check_val("blink_bcd", time_bcd, 16'h2135);
    check_val("blink_mask", blank_mask, 4'b0010);

    // order fault
    fv0 = fv_cnt; oe0 = oe_cnt;
    hold(4'b0001, 7'h3F, 3);
    hold(4'b0100, 7'h5B, 3);
    hold(4'b0000, 7'h00, 2);
    check_val("order_oe", oe_cnt - oe0, 1);
    check_val("order_fv", fv_cnt - fv0, 0);
    check_val("order_bcd", time_bcd, 16'h2135);

    // illegal pattern, then a clean frame
    fv0 = fv_cnt;
    scan(7'h6D, 7'h4F, 7'h7A, 7'h5B);
    check_val("illegal_seg", seg_err, 1);
    check_val("illegal_fv", fv_cnt - fv0, 0);
    scan(7'h3F, 7'h3F, 7'h06, 7'h5B);
    check_val("after_illegal_bcd", time_bcd, 16'h2100);
    check_val("seg_sticky", seg_err, 1);

    // stall
    hold(4'b0000, 7'h00, 64);
    check_val("stall_stale", stale, 1);
    check_val("stall_bcd", time_bcd, 16'h2100);
    scan(7'h6D, 7'h4F, 7'h06, 7'h5B);
    check_val("unstall_stale", stale, 0);
    check_val("unstall_bcd", time_bcd, 16'h2135);

    // reset mid-scan after digit 1
    hold(4'b0001, 7'h6D, 3);
    hold(4'b0010, 7'h4F, 3);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    model_reset();
    check_all();
    check_val("midrst_bcd", time_bcd, 16'h0000);
    check_val("midrst_seg", seg_err, 0);
    Reset = 1'b1;
    fv0 = fv_cnt;
    hold(4'b0100, 7'h06, 3);
    hold(4'b1000, 7'h5B, 3);
    check_val("midrst_fv", fv_cnt - fv0, 0);
    check_val("midrst_bcd2", time_bcd, 16'h0000);

    // randomized scans
    for (int f = 0; f < 250; f++) begin
      am = 1'($urandom); pm = 1'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0) days = '0;
      else if (r == 3) days = 7'($urandom);
      else days = 7'(1 << $urandom_range(0, 6));
      for (int i = 0; i < 4; i++) begin
        sel = 4'(1 << i);
        r = $urandom_range(0, 99);
        if (r < 4) sel = 4'($urandom);
        else if (r < 8) sel = 4'(1 << $urandom_range(0, 3));
        pat = seg_tab[$urandom_range(0, 9)];
        r = $urandom_range(0, 99);
        if (r < 8) pat = '0;
        else if (r < 11) pat = 7'($urandom);
        hold(sel, pat, $urandom_range(SETTLE - 1, SETTLE + 2));
        if ($urandom_range(0, 3) == 0) hold(4'b0000, 7'h00, $urandom_range(1, 2));
      end
      if ($urandom_range(0, 24) == 0) hold(4'b0000, 7'h00, 70);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
